// File: rtl/video_sync_detect.sv
// Video sync detector: measures hs/vs timing, locks onto 260/312-line frames
// and produces active-area pixel coordinates and blanking flags.
module video_sync_detect #(
    parameter int HS_TO_ACTIVE = 208,
    parameter int H_ACTIVE     = 720,
    parameter int VS_TO_ACTIVE = 30,
    parameter int LINE_MIN     = 960,
    parameter int LINE_MAX     = 1088
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    output logic [10:0] o_x,
    output logic [8:0]  o_y,
    output logic        o_hblank,
    output logic        o_vblank,
    output logic        o_active,
    output logic        o_frame_start,
    output logic        o_locked,
    output logic        o_ntsc,
    output logic [10:0] o_line_len,
    output logic [9:0]  o_frame_lines,
    output logic        o_err
);

    localparam logic [10:0] H_FIRST = 11'(HS_TO_ACTIVE);
    localparam logic [10:0] H_LAST  = 11'(HS_TO_ACTIVE + H_ACTIVE - 1);
    localparam logic [9:0]  V_FIRST = 10'(VS_TO_ACTIVE);
    localparam logic [10:0] L_MIN   = 11'(LINE_MIN);
    localparam logic [10:0] L_MAX   = 11'(LINE_MAX);

    typedef enum logic [1:0] {SEARCH, LINE_OK, LOCKED} state_t;

    state_t      state, state_next;
    logic        err_next;
    logic        hs_q, vs_q, pending;
    logic [10:0] h_cnt, new_len;
    logic [9:0]  v_cnt, new_frame;
    logic        hs_fall, vs_fall, frame_evt;
    logic        line_good, line_same, frame_std, frame_same, violation;
    logic        h_in, v_in;
    logic [9:0]  v_rows, v_last;

    assign hs_fall   = i_pix_stb & hs_q & ~i_hs;
    assign vs_fall   = i_pix_stb & vs_q & ~i_vs;
    // A vs edge landing on the same strobe as an hs edge is consumed immediately.
    assign frame_evt = hs_fall & (pending | vs_fall);
    assign new_len   = h_cnt + 11'd1;
    assign new_frame = v_cnt + 10'd1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            pending       <= 1'b0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            o_line_len    <= '0;
            o_frame_lines <= '0;
            o_ntsc        <= 1'b0;
        end else begin
            if (i_pix_stb) begin
                hs_q <= i_hs;
                vs_q <= i_vs;
                if (hs_fall)
                    h_cnt <= '0;
                else if (h_cnt != 11'h7FF)
                    h_cnt <= h_cnt + 11'd1;
            end
            if (hs_fall)
                o_line_len <= new_len;
            if (frame_evt) begin
                v_cnt         <= '0;
                pending       <= 1'b0;
                o_frame_lines <= new_frame;
                if (new_frame == 10'd260)
                    o_ntsc <= 1'b1;
                else if (new_frame == 10'd312)
                    o_ntsc <= 1'b0;
            end else begin
                if (hs_fall && v_cnt != 10'h3FF)
                    v_cnt <= v_cnt + 10'd1;
                if (vs_fall)
                    pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= SEARCH;
            o_err <= 1'b0;
        end else begin
            state <= state_next;
            o_err <= err_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        line_good  = (new_len >= L_MIN) && (new_len <= L_MAX);
        line_same  = (new_len == o_line_len);
        frame_std  = (new_frame == 10'd260) || (new_frame == 10'd312);
        frame_same = (new_frame == o_frame_lines);
        violation  = (hs_fall && !(line_good && line_same))
                   || (frame_evt && !frame_same)
                   || (h_cnt == 11'h7FF);
        case (state)
            SEARCH:
                if (hs_fall && line_good && line_same)
                    state_next = LINE_OK;
            LINE_OK:
                if (violation) begin
                    state_next = SEARCH;
                    err_next   = 1'b1;
                end else if (frame_evt && frame_std) begin
                    state_next = LOCKED;
                end
            LOCKED:
                if (violation) begin
                    state_next = SEARCH;
                    err_next   = 1'b1;
                end
            default:
                state_next = SEARCH;
        endcase
    end

    assign o_locked = (state == LOCKED);

    always_comb begin
        h_in     = (h_cnt >= H_FIRST) && (h_cnt <= H_LAST);
        o_x      = h_in ? (h_cnt - H_FIRST) : '0;
        o_hblank = ~h_in;

        v_rows   = o_ntsc ? 10'd200 : 10'd256;
        v_last   = V_FIRST + v_rows - 10'd1;
        v_in     = (v_cnt >= V_FIRST) && (v_cnt <= v_last);
        if (v_in)
            o_y = 9'(v_cnt - V_FIRST);
        else if (v_cnt > v_last)
            o_y = 9'(v_rows - 10'd1);
        else
            o_y = '0;
        o_vblank = ~v_in;

        o_active      = h_in & v_in & o_locked;
        o_frame_start = (v_cnt == V_FIRST) && (h_cnt == H_FIRST) && i_pix_stb && o_locked;
    end

endmodule
